// File: rtl/uart_cmd_host_pkg.sv
// Shared types, opcodes and frame helpers for the UART command host.
// The frame helpers define the exact wire order of each command's bytes.
package uart_cmd_host_pkg;

    typedef enum logic [1:0] {
        WR      = 2'd0,
        RD      = 2'd1,
        ALU_OP  = 2'd2,
        ALU_NOP = 2'd3
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } host_state_t;

    localparam logic [7:0] OP_WR      = 8'hAA;
    localparam logic [7:0] OP_RD      = 8'hBB;
    localparam logic [7:0] OP_ALU     = 8'hCC;
    localparam logic [7:0] OP_ALU_NOP = 8'hDD;

    typedef struct packed {
        logic [2:0] tx_len;
        logic [1:0] rx_len;
    } frame_len_t;

    // Index 0 is the first byte on the wire.
    typedef logic [3:0][7:0] frame_t;

    function automatic frame_len_t frame_len(input cmd_t cmd);
        frame_len_t len;
        case (cmd)
            WR:      len = '{tx_len: 3'd3, rx_len: 2'd0};
            RD:      len = '{tx_len: 3'd2, rx_len: 2'd1};
            ALU_OP:  len = '{tx_len: 3'd4, rx_len: 2'd2};
            default: len = '{tx_len: 3'd2, rx_len: 2'd2};
        endcase
        return len;
    endfunction

    function automatic frame_t frame_bytes(input cmd_t cmd, input logic [7:0] addr,
                                           input logic [7:0] data, input logic [7:0] op_a,
                                           input logic [7:0] op_b, input logic [7:0] fun);
        frame_t f;
        f = '0;
        case (cmd)
            WR: begin
                f[0] = OP_WR;
                f[1] = addr;
                f[2] = data;
            end
            RD: begin
                f[0] = OP_RD;
                f[1] = addr;
            end
            ALU_OP: begin
                f[0] = OP_ALU;
                f[1] = op_a;
                f[2] = op_b;
                f[3] = fun;
            end
            default: begin
                f[0] = OP_ALU_NOP;
                f[1] = fun;
            end
        endcase
        return f;
    endfunction

endpackage

// File: rtl/uart_cmd_host_rsp_timer.sv
// Response watchdog: counts idle cycles while enabled and flags expiry on the
// cycle the count reaches timeout-1. A zero timeout never expires.
module uart_cmd_host_rsp_timer #(
    parameter int TIMEOUT_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic                 i_enable,
    input  logic [TIMEOUT_W-1:0] i_timeout,
    output logic                 o_expire
);

    logic [TIMEOUT_W-1:0] count;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (i_enable) begin
            count <= count + TIMEOUT_W'(1);
        end
    end

    assign o_expire = i_enable && (i_timeout != '0) && (count == i_timeout - TIMEOUT_W'(1));

endmodule

// File: rtl/uart_cmd_host.sv
// Host-side command initiator: serializes one command into frame bytes, then
// gathers the LSB-first response or reports timeout / parity error.
module uart_cmd_host
    import uart_cmd_host_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_OUT_WIDTH = 16,
    parameter int TIMEOUT_W     = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [1:0]               i_cmd_type,
    input  logic [ADDR_WIDTH-1:0]    i_cmd_addr,
    input  logic [DATA_WIDTH-1:0]    i_cmd_data,
    input  logic [DATA_WIDTH-1:0]    i_cmd_op_a,
    input  logic [DATA_WIDTH-1:0]    i_cmd_op_b,
    input  logic [3:0]               i_cmd_fun,
    input  logic [TIMEOUT_W-1:0]     i_timeout,
    output logic [7:0]               o_tx_byte,
    output logic                     o_tx_valid,
    input  logic                     i_tx_ready,
    input  logic [7:0]               i_rx_byte,
    input  logic                     i_rx_valid,
    input  logic                     i_rx_par_err,
    output logic                     o_rsp_valid,
    output logic [ALU_OUT_WIDTH-1:0] o_rsp_data,
    output logic                     o_rsp_err,
    output logic                     o_busy,
    output logic [1:0]               o_dbg_state
);

    // Handshakes: a command transfers when i_cmd_valid && o_cmd_ready; a frame
    // byte transfers when o_tx_valid && i_tx_ready, and o_tx_byte/o_tx_valid
    // stay put until then; i_rx_valid is a one-cycle strobe with no backpressure.

    host_state_t      state;
    frame_t           frame;
    frame_t           frame_in;
    frame_len_t       len_in;
    cmd_t             cmd_in;
    logic [1:0]       tx_idx;
    logic [1:0]       tx_last;
    logic [1:0]       rx_len;
    logic [1:0]       rx_cnt;
    logic [1:0][7:0]  rx_buf;
    logic [1:0][7:0]  rx_buf_nxt;
    logic             err;
    logic             err_nxt;
    logic             rx_take;
    logic             timer_expire;

    assign cmd_in   = cmd_t'(i_cmd_type);
    assign len_in   = frame_len(cmd_in);
    assign frame_in = frame_bytes(cmd_in, 8'(i_cmd_addr), 8'(i_cmd_data),
                                  8'(i_cmd_op_a), 8'(i_cmd_op_b), 8'(i_cmd_fun));

    assign rx_take = (state == WAIT_RSP) && i_rx_valid;
    assign err_nxt = err | (rx_take & i_rx_par_err);

    // Response word as it will look once this cycle's byte (if any) lands.
    always_comb begin
        rx_buf_nxt = rx_buf;
        if (rx_take) begin
            rx_buf_nxt[rx_cnt[0]] = i_rx_byte;
        end
    end

    uart_cmd_host_rsp_timer #(
        .TIMEOUT_W(TIMEOUT_W)
    ) u_rsp_timer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  ((state != WAIT_RSP) || i_rx_valid),
        .i_enable (state == WAIT_RSP),
        .i_timeout(i_timeout),
        .o_expire (timer_expire)
    );

    assign o_dbg_state = state;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= IDLE;
            o_cmd_ready <= 1'b1;
            o_busy      <= 1'b0;
            o_tx_valid  <= 1'b0;
            o_tx_byte   <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_rsp_err   <= 1'b0;
            frame       <= '0;
            tx_idx      <= '0;
            tx_last     <= '0;
            rx_len      <= '0;
            rx_cnt      <= '0;
            rx_buf      <= '0;
            err         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        frame       <= frame_in;
                        tx_idx      <= '0;
                        tx_last     <= 2'(len_in.tx_len - 3'd1);
                        rx_len      <= len_in.rx_len;
                        rx_cnt      <= '0;
                        rx_buf      <= '0;
                        err         <= 1'b0;
                        o_tx_byte   <= frame_in[0];
                        o_tx_valid  <= 1'b1;
                        o_cmd_ready <= 1'b0;
                        o_busy      <= 1'b1;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (i_tx_ready) begin
                        if (tx_idx == tx_last) begin
                            o_tx_valid <= 1'b0;
                            if (rx_len == 2'd0) begin
                                o_rsp_valid <= 1'b1;
                                o_rsp_data  <= ALU_OUT_WIDTH'(rx_buf_nxt);
                                o_rsp_err   <= err_nxt;
                                state       <= DONE;
                            end else begin
                                state <= WAIT_RSP;
                            end
                        end else begin
                            tx_idx    <= tx_idx + 2'd1;
                            o_tx_byte <= frame[tx_idx + 2'd1];
                        end
                    end
                end
                WAIT_RSP: begin
                    // A byte arriving on the expiry cycle wins over the timeout.
                    if (rx_take) begin
                        rx_buf <= rx_buf_nxt;
                        err    <= err_nxt;
                        rx_cnt <= rx_cnt + 2'd1;
                        if (rx_cnt + 2'd1 == rx_len) begin
                            o_rsp_valid <= 1'b1;
                            o_rsp_data  <= ALU_OUT_WIDTH'(rx_buf_nxt);
                            o_rsp_err   <= err_nxt;
                            state       <= DONE;
                        end
                    end else if (timer_expire) begin
                        o_rsp_valid <= 1'b1;
                        o_rsp_data  <= ALU_OUT_WIDTH'(rx_buf);
                        o_rsp_err   <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    o_rsp_valid <= 1'b0;
                    o_cmd_ready <= 1'b1;
                    o_busy      <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_cmd_host.md
# uart_cmd_host

Host-side command initiator for the UART register/ALU command protocol. It accepts one parallel command request, serializes it into protocol frame bytes on a byte-stream TX interface, then collects the response bytes from a byte-stream RX interface. It returns read data or ALU results, or flags a timeout or parity error. It sits between a test or host controller and a UART TX/RX pair that talks to the system's command controller.

## Interface
Parameters:
- DATA_WIDTH, 8, register and operand width
- ADDR_WIDTH, 4, register address width; the address byte is zero-extended to 8 bits
- ALU_OUT_WIDTH, 16, response data width
- TIMEOUT_W, 16, width of the timeout counter

Ports (one clock; reset is asynchronous and active-low):
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous active-low reset
- i_cmd_valid  in  1  command request
- o_cmd_ready  out  1  high only in IDLE
- i_cmd_type  in  2  cmd_t: WR, RD, ALU_OP, ALU_NOP
- i_cmd_addr  in  ADDR_WIDTH  register address
- i_cmd_data  in  DATA_WIDTH  write data
- i_cmd_op_a, i_cmd_op_b  in  DATA_WIDTH  ALU operands
- i_cmd_fun  in  4  ALU function code
- i_timeout  in  TIMEOUT_W  response timeout in cycles; 0 disables the timeout
- o_tx_byte  out  8  frame byte
- o_tx_valid  out  1  frame byte valid
- i_tx_ready  in  1  downstream accepts the byte
- i_rx_byte  in  8  received byte
- i_rx_valid  in  1  one-cycle strobe, no backpressure
- i_rx_par_err  in  1  qualifies i_rx_valid
- o_rsp_valid  out  1  one-cycle completion pulse
- o_rsp_data  out  ALU_OUT_WIDTH  response data
- o_rsp_err  out  1  valid with o_rsp_valid; set on timeout or parity error
- o_busy  out  1  high in any state except IDLE

## Operation
Frame formats:
- WR = AA, addr, data; no response bytes
- RD = BB, addr; 1 response byte
- ALU_OP = CC, A, B, fun; 2 response bytes
- ALU_NOP = DD, fun; 2 response bytes

Response rules:
- Response bytes arrive LSB first.
- RD zero-extends its byte into o_rsp_data.

State machine:
- IDLE -> SEND on i_cmd_valid&&o_cmd_ready. All command fields are captured in that cycle.
- SEND drives the byte at index tx_idx. tx_idx advances on o_tx_valid&&i_tx_ready. o_tx_byte is held stable while o_tx_valid is high and i_tx_ready is low.
- Last byte accepted: WR goes to DONE; all other types go to WAIT_RSP with rx_cnt=0 and timer=0.
- WAIT_RSP: each i_rx_valid stores the byte at rx_cnt, increments rx_cnt, clears the timer, and ORs i_rx_par_err into a sticky err flag. Expected count reached goes to DONE.
- WAIT_RSP: if i_timeout!=0 and timer==i_timeout-1 with no i_rx_valid that cycle, go to DONE with err=1. Partial data is kept; unfilled bytes read 0.
- DONE: o_rsp_valid=1 for exactly one cycle, then IDLE.

Boundary rules:
- i_rx_valid outside WAIT_RSP is ignored and does not set err.
- i_rx_valid in the same cycle the timeout would fire takes priority; there is no timeout that cycle.
- Reset mid-operation aborts immediately to IDLE. No o_rsp_valid is issued for the aborted command.

## Timing
Reset values:
- o_tx_valid, o_rsp_valid, o_rsp_err, o_busy = 0
- o_tx_byte, o_rsp_data = 0
- o_cmd_ready = 1

Latency and throughput:
- Command accept to first o_tx_valid: 1 cycle.
- With i_tx_ready tied high, one byte is sent per cycle. WR: o_rsp_valid 1 cycle after the 3rd byte is accepted.
- Last response byte strobe to o_rsp_valid: 1 cycle.
- Timeout: o_rsp_valid occurs i_timeout+1 cycles after the last TX handshake, or after the last received byte.

Output hold:
- o_rsp_data and o_rsp_err are registered.
- They hold their values until the next DONE or reset.

## Structure
- Shared package holds:
  - cmd_t enum
  - host_state_t enum {IDLE, SEND, WAIT_RSP, DONE}
  - opcode constants OP_WR=8'hAA, OP_RD=8'hBB, OP_ALU=8'hCC, OP_ALU_NOP=8'hDD
  - frame-length function returning (tx_len, rx_len) per cmd_t
- One sub-module, rsp_timer: TIMEOUT_W counter with clear, enable and expire outputs, on i_clk/i_reset.

## Test plan
- WR addr=4'h4 data=8'h5A, i_tx_ready=1 -> bytes AA,04,5A on consecutive cycles; o_rsp_valid with err=0 and data=0.
- RD addr=4'h2, response byte 8'h81 -> TX BB,02; o_rsp_data=16'h0081, err=0.
- ALU_OP A=8'h0C, B=8'h03, fun=4'h2, response bytes 24,00; i_tx_ready toggling every other cycle -> TX CC,0C,03,02 with each byte stable while stalled; o_rsp_data=16'h0024.
- ALU_NOP fun=4'h0, i_timeout=10, only one response byte 8'h11 -> o_rsp_valid 11 cycles after that byte; err=1; data=16'h0011.
- RD with i_rx_par_err=1 on the response byte -> err=1; then a stray i_rx_valid while IDLE -> no effect.
- Reset asserted during SEND of ALU_OP -> all outputs return to reset values; no o_rsp_valid; next WR completes normally.
